// File: rtl/fp_recip_iter.sv
`default_nettype none
// ============================================================================
//  Module   : fp_recip_iter
//  Function : Iterative floating-point reciprocal. It takes a linear seed and
//             applies Newton-Raphson refinement on one shared multiplier.
//  Revision : 1.0  initial release
// ============================================================================
module fp_recip_iter #(
    parameter int NEXP  = 8,
    parameter int NSIG  = 7,
    parameter int ITERS = 2,
    parameter int W     = 2*NSIG+6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NEXP+NSIG:0]   a,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NEXP+NSIG:0]   r,
    output logic [2:0]           flags
);

    localparam int N    = 1 + NEXP + NSIG;
    localparam int BIAS = 2**(NEXP-1) - 1;
    localparam int MW   = W + 2;
    localparam int EW   = NEXP + 2;
    localparam int CW   = (ITERS > 1) ? $clog2(ITERS) : 1;

    localparam logic [MW-1:0] C_K1       = MW'((64'd24 << W) / 64'd17);
    localparam logic [MW-1:0] C_K2       = MW'((64'd8  << W) / 64'd17);
    localparam logic [MW-1:0] C_TWO      = MW'(64'd2 << W);
    localparam logic [EW-1:0] C_TWO_BIAS = EW'(2*BIAS);
    localparam logic [CW-1:0] C_LAST     = CW'(ITERS-1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEED  = 3'd1,
        S_MUL_T = 3'd2,
        S_MUL_X = 3'd3,
        S_ROUND = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_sign;
    logic [NEXP-1:0]     r_exp;
    logic [NSIG-1:0]     r_frac;
    logic [MW-1:0]       r_m;
    logic [MW-1:0]       r_x;
    logic [MW-1:0]       r_t;
    logic [CW-1:0]       r_iter;
    logic [N-1:0]        r_res;
    logic [2:0]          r_flags;

    // Operand decode
    logic                w_a_sign;
    logic [NEXP-1:0]     w_a_exp;
    logic [NSIG-1:0]     w_a_frac;
    logic                w_exp_zero;
    logic                w_exp_max;
    logic                w_special;
    logic                w_accept;
    logic [MW-1:0]       w_a_m;
    logic [N-1:0]        w_spec_r;
    logic [2:0]          w_spec_f;

    assign w_a_sign   = a[N-1];
    assign w_a_exp    = a[N-2:NSIG];
    assign w_a_frac   = a[NSIG-1:0];
    assign w_exp_zero = (w_a_exp == '0);
    assign w_exp_max  = &w_a_exp;
    assign w_special  = w_exp_zero | w_exp_max;
    assign w_accept   = in_valid & in_ready;
    assign w_a_m      = {2'b01, w_a_frac, {(W-NSIG){1'b0}}};

    // Subnormals are treated as signed zero.
    always_comb begin
        w_spec_r = '0;
        w_spec_f = 3'b000;
        if (w_exp_zero) begin
            w_spec_r = {w_a_sign, {NEXP{1'b1}}, {NSIG{1'b0}}};
            w_spec_f = 3'b010;
        end else if (w_a_frac == '0) begin
            w_spec_r = {w_a_sign, {(N-1){1'b0}}};
        end else begin
            w_spec_r = {1'b0, {NEXP{1'b1}}, 1'b1, {(NSIG-1){1'b0}}};
            w_spec_f = 3'b100;
        end
    end

    // Shared multiplier. While idle it forms the seed product (8/17)*m, so the
    // seed is already registered when SEED begins the first refinement.
    logic [MW-1:0]       w_op_a;
    logic [MW-1:0]       w_op_b;
    logic [2*MW-1:0]     w_prod;
    logic [MW-1:0]       w_prod_q;
    logic [MW-1:0]       w_seed;
    logic                w_unused;

    always_comb begin
        w_op_a = r_m;
        w_op_b = r_x;
        case (r_state)
            S_IDLE: begin
                w_op_a = C_K2;
                w_op_b = w_a_m;
            end
            S_MUL_X: begin
                w_op_a = r_x;
                w_op_b = C_TWO - r_t;
            end
            default: begin
                w_op_a = r_m;
                w_op_b = r_x;
            end
        endcase
    end

    assign w_prod   = w_op_a * w_op_b;
    assign w_prod_q = w_prod[W+MW-1:W];
    assign w_seed   = C_K1 - w_prod_q;
    assign w_unused = ^{w_prod[W-1:0], w_prod[2*MW-1:W+MW]};

    // Rounding. For frac != 0 the estimate x lies in (0.5,1), so y = 2x has
    // its leading one at bit W-1 of x.
    logic [NSIG-1:0]     w_yfrac;
    logic                w_guard;
    logic                w_sticky;
    logic                w_frac_nz;
    logic                w_rnd_up;
    logic [NSIG:0]       w_mant_sum;
    logic                w_carry;
    logic [EW-1:0]       w_re;
    logic [NSIG-1:0]     w_fr;
    logic                w_uf;
    logic [N-1:0]        w_rnd_r;

    assign w_yfrac    = r_x[W-2 -: NSIG];
    assign w_guard    = r_x[W-2-NSIG];
    assign w_sticky   = |r_x[W-3-NSIG:0];
    assign w_frac_nz  = |r_frac;
    assign w_rnd_up   = w_guard & (w_sticky | w_yfrac[0]);
    assign w_mant_sum = {1'b0, w_yfrac} + {{NSIG{1'b0}}, w_rnd_up};
    assign w_carry    = w_mant_sum[NSIG];
    assign w_re       = C_TWO_BIAS - {2'b00, r_exp}
                        - {{(EW-1){1'b0}}, w_frac_nz}
                        + {{(EW-1){1'b0}}, w_frac_nz & w_carry};
    assign w_fr       = w_frac_nz ? w_mant_sum[NSIG-1:0] : '0;
    assign w_uf       = w_re[EW-1] | (w_re == '0);
    assign w_rnd_r    = w_uf ? {r_sign, {(N-1){1'b0}}}
                             : {r_sign, w_re[NEXP-1:0], w_fr};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_state_nxt = w_special ? S_DONE : S_SEED;
            S_SEED:  w_state_nxt = S_MUL_X;
            S_MUL_T: w_state_nxt = S_MUL_X;
            S_MUL_X: w_state_nxt = (r_iter == C_LAST) ? S_ROUND : S_MUL_T;
            S_ROUND: w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sign  <= 1'b0;
            r_exp   <= '0;
            r_frac  <= '0;
            r_m     <= '0;
            r_x     <= '0;
            r_t     <= '0;
            r_iter  <= '0;
            r_res   <= '0;
            r_flags <= 3'b000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sign <= w_a_sign;
                        r_exp  <= w_a_exp;
                        r_frac <= w_a_frac;
                        r_m    <= w_a_m;
                        r_x    <= w_seed;
                        r_iter <= '0;
                        if (w_special) begin
                            r_res   <= w_spec_r;
                            r_flags <= w_spec_f;
                        end
                    end
                end
                S_SEED, S_MUL_T: r_t <= w_prod_q;
                S_MUL_X: begin
                    r_x    <= w_prod_q;
                    r_iter <= r_iter + CW'(1);
                end
                S_ROUND: begin
                    r_res   <= w_rnd_r;
                    r_flags <= {2'b00, w_uf};
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign r         = r_res;
    assign flags     = r_flags;

endmodule
`default_nettype wire
